// File: rtl/beam_threshold_loader.sv
// Per-beam threshold register file plus the sequencer that pushes every beam pair
// into beam_alignment (A write, B write, update, gap). Optional: BEAM_LOADER_SKIP_EN.
module beam_threshold_loader #(
    parameter int                     NBEAMS       = 46,
    parameter int                     THRESH_BITS  = 18,
    parameter logic [THRESH_BITS-1:0] THRESH_RESET = 18'd6050,
    parameter int                     ADDR_BITS    = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wr_en_i,
    input  logic [ADDR_BITS-1:0]   wr_addr_i,
    input  logic [THRESH_BITS-1:0] wr_data_i,
    input  logic                   load_i,
`ifdef BEAM_LOADER_SKIP_EN
    input  logic [NBEAMS/2-1:0]    skip_mask_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic [THRESH_BITS-1:0] thresh_o,
    output logic [NBEAMS-1:0]      thresh_ce_o,
    output logic                   update_o,
    output logic [2:0]             state_o
);

    localparam int NPAIRS    = NBEAMS / 2;
    localparam int PAIR_BITS = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam int IDX_BITS  = PAIR_BITS + 1;
    localparam logic [ADDR_BITS:0] NBEAMS_W = (ADDR_BITS + 1)'(NBEAMS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_A   = 3'd1,
        S_B   = 3'd2,
        S_UPD = 3'd3,
        S_GAP = 3'd4
    } state_t;

    state_t                 state;
    logic [PAIR_BITS-1:0]   p;
    logic [THRESH_BITS-1:0] thr [NBEAMS];
    logic [NPAIRS-1:0]      load_mask;
    logic [NPAIRS-1:0]      mask_q;
    logic                   first_found;
    logic [PAIR_BITS-1:0]   first_idx;
    logic                   next_found;
    logic [PAIR_BITS-1:0]   next_idx;

    // Handshake: load_i is a one-cycle request honoured only in IDLE (dropped otherwise);
    // busy_o is high from the cycle after acceptance through the last gap cycle, and
    // done_o pulses in the first IDLE cycle that follows. No queueing of requests.

`ifdef BEAM_LOADER_SKIP_EN
    assign load_mask = skip_mask_i;
`else
    assign load_mask = '0;
`endif

    assign state_o = state;

    function automatic logic [NBEAMS-1:0] onehot(input logic [IDX_BITS-1:0] idx);
        logic [NBEAMS-1:0] r;
        r = '0;
        for (int i = 0; i < NBEAMS; i++) begin
            r[i] = (IDX_BITS'(i) == idx);
        end
        return r;
    endfunction

    // Lowest unmasked pair for a new load, and lowest unmasked pair above p for the next step.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int i = NPAIRS - 1; i >= 0; i--) begin
            if (!load_mask[i]) begin
                first_found = 1'b1;
                first_idx   = PAIR_BITS'(i);
            end
            if (!mask_q[i] && (PAIR_BITS'(i) > p)) begin
                next_found = 1'b1;
                next_idx   = PAIR_BITS'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NBEAMS; i++) begin
                thr[i] <= THRESH_RESET;
            end
        end else if (wr_en_i && ({1'b0, wr_addr_i} < NBEAMS_W)) begin
            thr[wr_addr_i] <= wr_data_i;
        end
    end

    // Outputs are loaded on the edge that enters each state, so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            p           <= '0;
            mask_q      <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            update_o <= 1'b0;
            case (state)
                IDLE: begin
                    busy_o      <= 1'b0;
                    thresh_o    <= '0;
                    thresh_ce_o <= '0;
                    if (load_i) begin
                        mask_q <= load_mask;
                        if (first_found) begin
                            state       <= S_A;
                            p           <= first_idx;
                            busy_o      <= 1'b1;
                            thresh_o    <= thr[{first_idx, 1'b1}];
                            thresh_ce_o <= onehot({first_idx, 1'b1});
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                S_A: begin
                    state       <= S_B;
                    thresh_o    <= thr[{p, 1'b0}];
                    thresh_ce_o <= onehot({p, 1'b0});
                end
                S_B: begin
                    state       <= S_UPD;
                    thresh_ce_o <= '0;
                    update_o    <= 1'b1;
                end
                S_UPD: begin
                    state       <= S_GAP;
                    thresh_o    <= '0;
                    thresh_ce_o <= '0;
                end
                S_GAP: begin
                    if (next_found) begin
                        state       <= S_A;
                        p           <= next_idx;
                        thresh_o    <= thr[{next_idx, 1'b1}];
                        thresh_ce_o <= onehot({next_idx, 1'b1});
                    end else begin
                        state  <= IDLE;
                        p      <= '0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    thresh_o    <= '0;
                    thresh_ce_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beam_threshold_loader.sv
// Directed bench for beam_threshold_loader: behavioural load model compared every cycle,
// plus hand-computed checks on latency, per-beam values and pulse counts.
module tb_beam_threshold_loader;

    localparam int NB     = 46;
    localparam int NPAIRS = NB / 2;
    localparam int TB     = 18;
    localparam int AB     = 6;
    localparam int RSTV   = 6050;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [TB-1:0] wr_data = '0;
    logic          load = 1'b0;
    logic [NPAIRS-1:0] skip_mask = '0;
    logic          busy, done, update;
    logic [TB-1:0] thresh;
    logic [NB-1:0] thresh_ce;
    logic [2:0]    state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    beam_threshold_loader dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .load_i      (load),
`ifdef BEAM_LOADER_SKIP_EN
        .skip_mask_i (skip_mask),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .thresh_o    (thresh),
        .thresh_ce_o (thresh_ce),
        .update_o    (update),
        .state_o     (state_dbg)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Model: a load is a list of unmasked pairs, each taking four cycles (A, B, update, gap).
    int          m_thr [NB];
    int          m_pairs [$];
    bit          m_active = 0;
    bit          m_valid = 0;
    int          m_k = 0;
    int          m_hold = 0;
    logic        e_busy, e_done, e_upd;
    logic [NB-1:0] e_ce;
    logic [TB-1:0] e_th;

    always @(posedge clk) begin
        int pr;
        if (rst) begin
            m_active = 0;
            for (int b = 0; b < NB; b++) m_thr[b] = RSTV;
            e_busy = 0; e_done = 0; e_upd = 0; e_ce = '0; e_th = '0;
        end else begin
            e_done = 0;
            if (m_active) begin
                m_k++;
                if (m_k == 4 * m_pairs.size()) begin
                    m_active = 0;
                    e_done = 1;
                end
            end else if (load) begin
                m_pairs.delete();
                for (int q = 0; q < NPAIRS; q++) if (!skip_mask[q]) m_pairs.push_back(q);
                if (m_pairs.size() == 0) e_done = 1;
                else begin
                    m_active = 1;
                    m_k = 0;
                end
            end
            e_busy = m_active; e_upd = 0; e_ce = '0; e_th = '0;
            if (m_active) begin
                pr = m_pairs[m_k / 4];
                case (m_k % 4)
                    0: begin e_th = TB'(m_thr[2*pr+1]); e_ce[2*pr+1] = 1'b1; end
                    1: begin e_th = TB'(m_thr[2*pr]); m_hold = m_thr[2*pr]; e_ce[2*pr] = 1'b1; end
                    2: begin e_th = TB'(m_hold); e_upd = 1'b1; end
                    default: ;
                endcase
            end
            if (wr_en && int'(wr_addr) < NB) m_thr[wr_addr] = int'(wr_data);
        end
        m_valid = 1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if ({busy, done, update, thresh_ce, thresh} !== {e_busy, e_done, e_upd, e_ce, e_th}) begin
                errors++;
                $display("FAIL model_cycle t=%0t got busy=%b done=%b upd=%b ce=%h th=%0d exp busy=%b done=%b upd=%b ce=%h th=%0d",
                         $time, busy, done, update, thresh_ce, thresh, e_busy, e_done, e_upd, e_ce, e_th);
            end
        end
    end

    // Per-beam capture of what was presented while that beam's enable was set.
    int cap_val [NB];
    int cap_cnt [NB];
    int upd_cnt = 0;

    always @(negedge clk) begin
        if (update) upd_cnt++;
        for (int b = 0; b < NB; b++) begin
            if (thresh_ce[b]) begin
                cap_val[b] = int'(thresh);
                cap_cnt[b]++;
            end
        end
    end

    task automatic clear_caps();
        for (int b = 0; b < NB; b++) begin
            cap_val[b] = -1;
            cap_cnt[b] = 0;
        end
        upd_cnt = 0;
    endtask

    task automatic do_write(input int addr, input int data);
        wr_en = 1'b1;
        wr_addr = AB'(addr);
        wr_data = TB'(data);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    int busy_cnt, done_cnt, done_at;

    // Pulse load now, then watch cycles 1..ncyc after the accepting edge.
    task automatic run_load(input int ncyc, input int load_at, input int wr_at,
                            input int w_addr, input int w_data, input int rst_at,
                            input int lit_i, input logic [NB-1:0] ce0, input int th0,
                            input logic [NB-1:0] ce1, input int th1);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        load = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            load = 1'b0; wr_en = 1'b0; rst = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (i == lit_i) begin
                check("lit_ce_first", 64'(thresh_ce), 64'(ce0));
                check("lit_th_first", 64'(thresh), 64'(th0));
            end
            if (i == lit_i + 1) begin
                check("lit_ce_second", 64'(thresh_ce), 64'(ce1));
                check("lit_th_second", 64'(thresh), 64'(th1));
            end
            if (i == load_at) load = 1'b1;
            if (i == wr_at) begin
                wr_en = 1'b1; wr_addr = AB'(w_addr); wr_data = TB'(w_data);
            end
            if (i == rst_at) rst = 1'b1;
        end
    endtask

    task automatic check_all_reset_vals(input string name);
        for (int b = 0; b < NB; b++) begin
            check(name, 64'(cap_val[b]), 64'(RSTV));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_ce", 64'(thresh_ce), 64'd0);
        check("reset_thresh", 64'(thresh), 64'd0);
        check("reset_update", 64'(update), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Plain load after reset
        clear_caps();
        run_load(100, -1, -1, 0, 0, -1, -1, '0, 0, '0, 0);
        check("t1_busy_cycles", 64'(busy_cnt), 64'd92);
        check("t1_done_count", 64'(done_cnt), 64'd1);
        check("t1_done_cycle", 64'(done_at), 64'd93);
        check("t1_update_count", 64'(upd_cnt), 64'd23);
        check_all_reset_vals("t1_beam_val");

        // Out-of-range writes are ignored
        do_write(46, 1);
        do_write(63, 2);
        clear_caps();
        run_load(100, -1, -1, 0, 0, -1, -1, '0, 0, '0, 0);
        check_all_reset_vals("t3_beam_val");
        check("t3_done_count", 64'(done_cnt), 64'd1);

        // Written thresholds and pair ordering
        do_write(0, 100);
        do_write(1, 200);
        do_write(45, 777);
        clear_caps();
        run_load(100, -1, -1, 0, 0, -1, 1, NB'(2), 200, NB'(1), 100);
        check("t2_beam0", 64'(cap_val[0]), 64'd100);
        check("t2_beam1", 64'(cap_val[1]), 64'd200);
        check("t2_beam45", 64'(cap_val[45]), 64'd777);
        check("t2_beam44", 64'(cap_val[44]), 64'(RSTV));
        check("t2_update_count", 64'(upd_cnt), 64'd23);

        // Second request while busy is dropped; write during pair 3 reaches pair 22
        clear_caps();
        run_load(100, 30, 13, 44, 5, -1, -1, '0, 0, '0, 0);
        check("t4_done_count", 64'(done_cnt), 64'd1);
        check("t4_busy_cycles", 64'(busy_cnt), 64'd92);
        check("t4_done_cycle", 64'(done_at), 64'd93);
        check("t4_beam44", 64'(cap_val[44]), 64'd5);
        check("t4_beam44_count", 64'(cap_cnt[44]), 64'd1);

        // Reset during pair 5 S_B aborts the load and restores thresholds
        do_write(3, 1234);
        clear_caps();
        run_load(100, -1, -1, 0, 0, 22, 22, NB'(1) << 10, RSTV, '0, 0);
        check("t5_done_count", 64'(done_cnt), 64'd0);
        check("t5_busy_cycles", 64'(busy_cnt), 64'd22);
        clear_caps();
        run_load(100, -1, -1, 0, 0, -1, -1, '0, 0, '0, 0);
        check_all_reset_vals("t5_beam_val");
        check("t5_done_count_after", 64'(done_cnt), 64'd1);

`ifdef BEAM_LOADER_SKIP_EN
        // Only pair 7 unmasked
        skip_mask = '1;
        skip_mask[7] = 1'b0;
        clear_caps();
        run_load(20, -1, -1, 0, 0, -1, 1, NB'(1) << 15, RSTV, NB'(1) << 14, RSTV);
        check("sk_busy_cycles", 64'(busy_cnt), 64'd4);
        check("sk_done_cycle", 64'(done_at), 64'd5);
        check("sk_beam15_count", 64'(cap_cnt[15]), 64'd1);
        check("sk_beam14_count", 64'(cap_cnt[14]), 64'd1);
        check("sk_beam16_count", 64'(cap_cnt[16]), 64'd0);
        check("sk_update_count", 64'(upd_cnt), 64'd1);

        // Everything masked: done the cycle after the request, never busy
        skip_mask = '1;
        clear_caps();
        run_load(10, -1, -1, 0, 0, -1, -1, '0, 0, '0, 0);
        check("sk_all_busy", 64'(busy_cnt), 64'd0);
        check("sk_all_done_cycle", 64'(done_at), 64'd1);
        check("sk_all_done_count", 64'(done_cnt), 64'd1);
        skip_mask = '0;
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/beam_threshold_loader.md
Name: beam_threshold_loader

Overview:
- Master/initiator side of the beam-trigger threshold-load interface (thresh/thresh_ce/update) that beam_alignment responds to.
- Holds a per-beam threshold register file that the host/AXI side writes.
- On a load request, sequences every beam pair through the A-write, B-write and update protocol, one pair at a time.
- Sits between the control register space and beam_alignment.

Parameters:
- NBEAMS, 46, beam count; must be even; pairs = NBEAMS/2.
- THRESH_BITS, 18, threshold width.
- THRESH_RESET, 18'd6050, value of every stored threshold after reset.
- ADDR_BITS, 6, beam address width; requires 2^ADDR_BITS >= NBEAMS.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- wr_en_i  input  1  host write strobe.
- wr_addr_i  input  ADDR_BITS  beam index to write.
- wr_data_i  input  THRESH_BITS  threshold value.
- load_i  input  1  single-cycle load request.
- busy_o  output  1  high while the sequencer is not IDLE.
- done_o  output  1  one-cycle pulse when a load completes.
- thresh_o  output  THRESH_BITS  to beam_alignment thresh_i.
- thresh_ce_o  output  NBEAMS  to beam_alignment thresh_ce_i.
- update_o  output  1  to beam_alignment update_i.

Behaviour:
- Reset: the clock and reset are one clock (clk_i) with a synchronous, active-high reset (rst_i). All outputs are 0, the FSM is IDLE, all thresholds return to THRESH_RESET. Reset mid-sequence aborts at the next edge: outputs go to 0, no done_o.
- Register file write: when wr_en_i=1 and wr_addr_i<NBEAMS, thr[wr_addr_i] <= wr_data_i at the edge. Out-of-range addresses are ignored. Writes are accepted while busy. A pair reads thr[] in its S_A cycle, so a write lands in the current load only if that pair has not yet reached S_A.
- All outputs are registered.
- FSM states: IDLE, S_A, S_B, S_UPD, S_GAP. Pair counter p runs 0..NBEAMS/2-1.
- IDLE: all outputs 0. If load_i=1, go to S_A with p=0. Any load_i seen while not IDLE is dropped (no queueing).
- S_A: thresh_o=thr[2p+1]; thresh_ce_o has only bit 2p+1 set.
- S_B: thresh_o=thr[2p]; thresh_ce_o has only bit 2p set.
- S_UPD: update_o=1; thresh_ce_o=0; thresh_o holds its S_B value.
- S_GAP: all outputs 0. If p=last, go to IDLE and assert done_o for 1 cycle (the first IDLE cycle). Otherwise p<=p+1 and go to S_A.
- Timing: 4 cycles per pair; a full load takes 2*NBEAMS cycles (92 at default).
- Latency: load_i sampled at edge N gives S_A outputs valid after edge N+1 (cycle N+1). busy_o is high for cycles N+1..N+2*NBEAMS. done_o is high at cycle N+2*NBEAMS+1.
- Same-cycle load_i and done_o: if load_i arrives in the done_o cycle, a new load starts and done_o still pulses.
- thresh_ce_o is never multi-hot. update_o is never asserted together with a nonzero thresh_ce_o.

Optional Feature:
- Macro: BEAM_LOADER_SKIP_EN.
- Enabled: adds input skip_mask_i [NBEAMS/2-1:0], sampled with load_i and held for that load. A pair with its mask bit set is skipped in 0 cycles; the FSM advances directly to the next unmasked pair. If all pairs are masked, done_o pulses the cycle after load_i and busy_o stays 0. Load length is 4*(unmasked pairs) cycles.
- Disabled: the port is absent and every pair is loaded.

Test Plan:
- Reset, then load_i with no writes → 23 pairs emitted, each thresh_o=6050; busy_o high for exactly 92 cycles; done_o pulses once at cycle 93.
- Write thr[0]=100, thr[1]=200, thr[45]=777, then load → pair0: S_A thresh_o=200 with ce bit1, S_B thresh_o=100 with ce bit0; pair22: S_A thresh_o=777 with ce bit45; update_o pulses 23 times.
- Write to addr 46 and addr 63 → ignored; full load shows all 6050.
- load_i pulsed at cycles 10 and 40 → second request ignored; only one done_o. Write thr[44]=5 during pair 3 → pair 22 emits 5 in S_B.
- rst_i asserted during pair 5 S_B → outputs 0 next cycle, no done_o; a subsequent load emits 6050 everywhere.
- With BEAM_LOADER_SKIP_EN and skip_mask_i=all ones except bit 7 → only beams 15 and 14 loaded; busy_o high for 4 cycles; done_o follows.
